// File: rtl/gem_trigger_pkg.sv
// rtl/gem_trigger_pkg.sv - K characters and frame-layout helpers for the GEM trigger link framer
package gem_trigger_pkg;

    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_6 = 8'hDC;

    localparam int TEST_CNT_BITS = 24;

    function automatic int frame_bits(input int frame_words);
        return frame_words * 16;
    endfunction

    function automatic int payload_bits(input int frame_words);
        return frame_words * 16 - 8;
    endfunction

    function automatic int group_bits(input int clusters_per_group, input int cluster_bits);
        return clusters_per_group * cluster_bits;
    endfunction

endpackage

// File: rtl/trigger_link_serializer.sv
// rtl/trigger_link_serializer.sv - per-lane frame latch, word mux and single-bit error injection
module trigger_link_serializer
    import gem_trigger_pkg::*;
#(
    parameter int FRAME_WORDS = 4,
    parameter int WCNT_BITS   = 2,
    parameter bit ERR_LANE    = 1'b0
) (
    input  logic                     clk_160,
    input  logic                     reset,
    input  logic                     load,
    input  logic [FRAME_WORDS*16-1:0] frame,
    input  logic [WCNT_BITS-1:0]     word_sel,
    input  logic                     inj_err,
    output logic [15:0]              tx_data,
    output logic [1:0]               tx_isk
);

    logic [FRAME_WORDS*16-1:0] frame_q;
    logic [FRAME_WORDS*16-1:0] frame_src;
    logic [15:0]               word;
    logic                      inj_pending;

    // Word 0 of a new frame goes out straight from the input on the latch cycle.
    assign frame_src = load ? frame : frame_q;
    assign word      = frame_src[word_sel*16 +: 16];

    always_ff @(posedge clk_160) begin
        if (reset) begin
            frame_q     <= '0;
            tx_data     <= {8'h00, K28_5};
            tx_isk      <= 2'b01;
            inj_pending <= 1'b0;
        end else begin
            if (load) begin
                frame_q <= frame;
            end
            tx_data     <= word ^ {7'd0, (ERR_LANE && inj_pending), 8'd0};
            tx_isk      <= (word_sel == '0) ? 2'b01 : 2'b00;
            inj_pending <= ERR_LANE && inj_err;
        end
    end

endmodule

// File: rtl/trigger_link_framer.sv
// rtl/trigger_link_framer.sv - fixed-latency GEM trigger framer with generic link-to-group map
module trigger_link_framer
    import gem_trigger_pkg::*;
#(
    parameter int NUM_LINKS          = 4,
    parameter int NUM_GROUPS         = 2,
    parameter int CLUSTERS_PER_GROUP = 4,
    parameter int CLUSTER_BITS       = 14,
    parameter int FRAME_WORDS        = 4,
    parameter int BC0_PERIOD         = 3564
) (
    input  logic                                             clk_160,
    input  logic                                             reset,
    input  logic                                             bx_strobe,
    input  logic                                             ttc_resync,
    input  logic [NUM_GROUPS*CLUSTERS_PER_GROUP*CLUSTER_BITS-1:0] clusters,
    input  logic                                             overflow,
    input  logic                                             ena_test_pat,
    input  logic                                             inj_err,
    output logic [NUM_LINKS*16-1:0]                          tx_data,
    output logic [NUM_LINKS*2-1:0]                           tx_isk,
    output logic                                             frame_start,
    output logic                                             bc0_out,
    output logic [7:0]                                       sync_err_cnt
);

    localparam int FRAME_BITS   = frame_bits(FRAME_WORDS);
    localparam int PAYLOAD_BITS = payload_bits(FRAME_WORDS);
    localparam int GROUP_BITS   = group_bits(CLUSTERS_PER_GROUP, CLUSTER_BITS);
    localparam int WCNT_BITS    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int BX_BITS      = (BC0_PERIOD > 1) ? $clog2(BC0_PERIOD) : 1;
    localparam logic [WCNT_BITS-1:0] LAST_WORD = WCNT_BITS'(FRAME_WORDS - 1);
    localparam logic [BX_BITS-1:0]   LAST_BX   = BX_BITS'(BC0_PERIOD - 1);

    if (GROUP_BITS + 8 != FRAME_BITS) begin : g_layout_err
        $error("cluster payload does not fill the frame");
    end

    logic [WCNT_BITS-1:0]     word_cnt;
    logic [WCNT_BITS-1:0]     word_nxt;
    logic [BX_BITS-1:0]       bx_cnt;
    logic [BX_BITS-1:0]       bx_base;
    logic [TEST_CNT_BITS-1:0] frame_cnt;
    logic                     overflow_pending;
    logic                     resync_pending;
    logic                     at_last;
    logic                     latch;
    logic                     is_bc0;
    logic [7:0]               ctrl;
    logic [PAYLOAD_BITS-1:0]  test_payload;

    assign at_last  = (word_cnt == LAST_WORD);
    assign latch    = bx_strobe || at_last;
    // A resync, pending or arriving on the latch cycle itself, makes this latch the BC0.
    assign bx_base  = (ttc_resync || resync_pending) ? '0 : bx_cnt;
    assign is_bc0   = (bx_base == '0);
    assign word_nxt = latch ? '0 : word_cnt + 1'b1;

    always_comb begin
        ctrl = K28_5;
        if (is_bc0) begin
            ctrl = K28_1;
        end else if (overflow || overflow_pending) begin
            ctrl = K28_6;
        end
    end

    always_comb begin
        test_payload = '0;
        for (int i = 0; i < PAYLOAD_BITS; i++) begin
            test_payload[i] = frame_cnt[i % TEST_CNT_BITS];
        end
    end

    always_ff @(posedge clk_160) begin
        if (reset) begin
            word_cnt         <= LAST_WORD;
            bx_cnt           <= '0;
            frame_cnt        <= '0;
            overflow_pending <= 1'b0;
            resync_pending   <= 1'b0;
            frame_start      <= 1'b0;
            bc0_out          <= 1'b0;
            sync_err_cnt     <= 8'd0;
        end else begin
            word_cnt    <= word_nxt;
            frame_start <= latch;
            bc0_out     <= latch && is_bc0;
            if (bx_strobe && !at_last && sync_err_cnt != 8'hFF) begin
                sync_err_cnt <= sync_err_cnt + 8'd1;
            end
            if (latch) begin
                bx_cnt           <= (bx_base == LAST_BX) ? '0 : bx_base + 1'b1;
                frame_cnt        <= frame_cnt + 1'b1;
                overflow_pending <= is_bc0 && (overflow || overflow_pending);
                resync_pending   <= 1'b0;
            end else if (ttc_resync) begin
                resync_pending <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_LINKS; i++) begin : g_lane
        localparam int GROUP = i % NUM_GROUPS;
        logic [PAYLOAD_BITS-1:0] payload;

        assign payload = ena_test_pat ? test_payload : clusters[GROUP*GROUP_BITS +: GROUP_BITS];

        trigger_link_serializer #(
            .FRAME_WORDS (FRAME_WORDS),
            .WCNT_BITS   (WCNT_BITS),
            .ERR_LANE    (i == 0)
        ) u_serializer (
            .clk_160  (clk_160),
            .reset    (reset),
            .load     (latch),
            .frame    ({payload, ctrl}),
            .word_sel (word_nxt),
            .inj_err  (inj_err),
            .tx_data  (tx_data[16*i +: 16]),
            .tx_isk   (tx_isk[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_trigger_link_framer.sv
// tb/tb_trigger_link_framer.sv - randomized self-checking bench for trigger_link_framer
module tb_trigger_link_framer;

    localparam int NL  = 4;
    localparam int NG  = 2;
    localparam int FW  = 4;
    localparam int PER = 3564;

    logic          clk_160 = 1'b0;
    logic          reset;
    logic          bx_strobe;
    logic          ttc_resync;
    logic [111:0]  clusters;
    logic          overflow;
    logic          ena_test_pat;
    logic          inj_err;
    logic [63:0]   tx_data;
    logic [7:0]    tx_isk;
    logic          frame_start;
    logic          bc0_out;
    logic [7:0]    sync_err_cnt;

    int total = 0;
    int bad   = 0;

    logic [63:0] m_frame [NL];
    int          m_k;
    int          m_bx;
    int          m_err;
    bit          m_ovf_pend;
    bit          m_rs_pend;
    bit          m_fs;
    bit          m_bc0;
    bit          m_in_rst;
    logic [23:0] m_fcnt;

    bit g_tp;
    bit g_rand_ovf;
    bit fix_c0;
    bit inj_window;
    int inj_hits;
    int inj_other;
    int bc0_cnt;

    always #5 clk_160 = ~clk_160;

    trigger_link_framer dut (
        .clk_160      (clk_160),
        .reset        (reset),
        .bx_strobe    (bx_strobe),
        .ttc_resync   (ttc_resync),
        .clusters     (clusters),
        .overflow     (overflow),
        .ena_test_pat (ena_test_pat),
        .inj_err      (inj_err),
        .tx_data      (tx_data),
        .tx_isk       (tx_isk),
        .frame_start  (frame_start),
        .bc0_out      (bc0_out),
        .sync_err_cnt (sync_err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit strobe, input bit resync, input bit ovf, input bit inj);
        logic [111:0] cl;
        logic [63:0]  exp_data;
        logic [63:0]  diff;
        logic [55:0]  pl;
        logic [7:0]   ctrl;
        bit           bc0;
        for (int w = 0; w < 4; w++) cl[w*28 +: 28] = 28'($urandom);
        if (fix_c0) cl[13:0] = 14'h1ABC;
        reset = rst; bx_strobe = strobe; ttc_resync = resync; overflow = ovf;
        ena_test_pat = g_tp; inj_err = inj; clusters = cl;
        @(posedge clk_160);
        #1;
        if (rst) begin
            m_k = FW - 1; m_bx = 0; m_err = 0; m_fcnt = '0;
            m_ovf_pend = 0; m_rs_pend = 0; m_fs = 0; m_bc0 = 0; m_in_rst = 1;
        end else begin
            m_in_rst = 0;
            if (strobe && m_k != FW - 1 && m_err < 255) m_err++;
            if (strobe || m_k == FW - 1) begin
                if (resync || m_rs_pend) m_bx = 0;
                bc0  = (m_bx == 0);
                ctrl = bc0 ? 8'h3C : ((ovf || m_ovf_pend) ? 8'hDC : 8'hBC);
                m_ovf_pend = bc0 && (ovf || m_ovf_pend);
                m_rs_pend  = 0;
                m_bx = (m_bx + 1) % PER;
                for (int l = 0; l < NL; l++) begin
                    pl = g_tp ? {m_fcnt[7:0], m_fcnt, m_fcnt} : cl[(l % NG)*56 +: 56];
                    m_frame[l] = {pl, ctrl};
                end
                m_fcnt = m_fcnt + 24'd1;
                m_k = 0; m_fs = 1; m_bc0 = bc0;
            end else begin
                if (resync) m_rs_pend = 1;
                m_k++; m_fs = 0; m_bc0 = 0;
            end
        end
        if (m_in_rst) exp_data = {4{16'h00BC}};
        else for (int l = 0; l < NL; l++) exp_data[16*l +: 16] = m_frame[l][16*m_k +: 16];
        if (inj_window) begin
            diff = tx_data ^ exp_data;
            if (diff == 64'h100) inj_hits++;
            else if (diff != 64'h0) inj_other++;
        end else begin
            check("tx_data", tx_data, exp_data);
        end
        check("tx_isk", tx_isk, (m_in_rst || m_k == 0) ? 8'h55 : 8'h00);
        check("frame_start", frame_start, m_fs);
        check("bc0_out", bc0_out, m_bc0);
        check("sync_err_cnt", sync_err_cnt, m_err);
        bc0_cnt += int'(bc0_out);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            cycle(0, (m_k == FW - 1) && ($urandom_range(3) != 0), 0, g_rand_ovf && ($urandom_range(7) == 0), 0);
    endtask

    task automatic align(input int k);
        for (int i = 0; i < FW && m_k != k; i++) cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [7:0]  b0;
        logic [23:0] val;
        logic [23:0] prev;
        reset = 1; bx_strobe = 0; ttc_resync = 0; clusters = '0;
        overflow = 0; ena_test_pat = 0; inj_err = 0;
        g_tp = 0; g_rand_ovf = 0; fix_c0 = 1; inj_window = 0;
        inj_hits = 0; inj_other = 0; bc0_cnt = 0; prev = '0;

        repeat (3) cycle(1, 0, 0, 0, 0);
        check("rst_data", tx_data, {4{16'h00BC}});
        check("rst_isk", tx_isk, 8'h55);
        check("rst_err", sync_err_cnt, 0);

        cycle(0, 1, 0, 0, 0);
        check("first_w0", tx_data[15:0], 16'hBC3C);
        check("first_bc0", bc0_out, 1);
        for (int w = 0; w < FW; w++) begin
            if (w > 0) cycle(0, 0, 0, 0, 0);
            check("lane2_eq_lane0", tx_data[47:32], m_frame[0][16*w +: 16]);
        end
        cycle(0, 1, 0, 0, 0);
        check("second_ctrl", tx_data[7:0], 8'hBC);

        fix_c0 = 0; g_rand_ovf = 1;
        run(40);
        bc0_cnt = 0;
        run(PER * FW);
        check("bc0_per_orbit", bc0_cnt, 1);

        run(37);
        align(1);
        cycle(0, 0, 1, 0, 0);
        align(FW - 1);
        cycle(0, 0, 0, 0, 0);
        check("resync_bc0", bc0_out, 1);

        g_rand_ovf = 0;
        run(8);
        align(FW - 1);
        cycle(0, 0, 1, 1, 0);
        check("ovf_bc0_ctrl", tx_data[7:0], 8'h3C);
        align(FW - 1);
        cycle(0, 1, 0, 0, 0);
        check("ovf_next_ctrl", tx_data[7:0], 8'hDC);
        align(FW - 1);
        cycle(0, 1, 0, 0, 0);
        check("ovf_after_ctrl", tx_data[7:0], 8'hBC);

        g_tp = 1;
        align(FW - 1);
        for (int f = 0; f < 6; f++) begin
            cycle(0, 1, 0, 0, 0);
            b0 = tx_data[15:8];
            cycle(0, 0, 0, 0, 0);
            val = {tx_data[15:0], b0};
            if (f > 0) check("tp_inc", val, prev + 24'd1);
            prev = val;
            cycle(0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
        end
        g_tp = 0;

        inj_window = 1;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        repeat (10) cycle(0, 0, 0, 0, 0);
        inj_window = 0;
        check("inj_hits", inj_hits, 1);
        check("inj_other", inj_other, 0);

        check("err_before", sync_err_cnt, 0);
        align(1);
        cycle(0, 1, 0, 0, 0);
        check("err_one", sync_err_cnt, 1);
        check("restart", frame_start, 1);
        repeat (300) cycle(0, 1, 0, 0, 0);
        check("err_sat", sync_err_cnt, 8'hFF);

        run(9);
        align(2);
        cycle(1, 0, 0, 0, 0);
        check("rst_mid_data", tx_data[15:0], 16'h00BC);
        check("rst_mid_isk", tx_isk[1:0], 2'b01);
        cycle(0, 1, 0, 0, 0);
        check("rst_rel_bc0", bc0_out, 1);
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trigger_link_framer.md
# trigger_link_framer

Parametrised fixed-latency framer for the GEM trigger fibres. Once per bunch crossing it latches a set of cluster groups and serialises each onto one of NUM_LINKS transceiver lanes as FRAME_WORDS 16-bit words at clk_160. It adds comma/BC0/overflow control characters, a PRBS-free counting test pattern and single-word error injection. It sits between the cluster packer and the GTX TX user interface, replacing the hard-wired 4-link mapping with a generic link-to-group map.

## Interface
Parameters:
- NUM_LINKS, 4: output lanes.
- NUM_GROUPS, 2: cluster groups. Lane i carries group i % NUM_GROUPS.
- CLUSTERS_PER_GROUP, 4: clusters per group.
- CLUSTER_BITS, 14: bits per cluster.
- FRAME_WORDS, 4: 16-bit words per BX.
- BC0_PERIOD, 3564: BX per orbit.
- Elaboration check: CLUSTERS_PER_GROUP*CLUSTER_BITS + 8 == FRAME_WORDS*16.

Ports:
- clk_160, in, 1: single clock, 160 MHz.
- reset, in, 1: synchronous, active-high.
- bx_strobe, in, 1: first clk_160 cycle of each BX.
- ttc_resync, in, 1: the next frame is BC0.
- clusters, in, NUM_GROUPS*CLUSTERS_PER_GROUP*CLUSTER_BITS: group g occupies slice g, with cluster 0 in the LSBs.
- overflow, in, 1: cluster overflow for this BX.
- ena_test_pat, in, 1: replace the payload with the BX counter pattern.
- inj_err, in, 1: one-cycle pulse requesting a single bit error.
- tx_data, out, NUM_LINKS*16: lane i occupies [16i+15:16i].
- tx_isk, out, NUM_LINKS*2: per-byte K flag.
- frame_start, out, 1: high with word 0 on tx_data.
- bc0_out, out, 1: high with word 0 of a BC0 frame.
- sync_err_cnt, out, 8: saturating count of misaligned strobes.

## Operation
- Frame layout is frame[FRAME_WORDS*16-1:0] = {payload, ctrl[7:0]}. Word k = frame[16k+15:16k]. Word 0 low byte is a K character: tx_isk bit 0 of each lane is 1 on word 0, and all other tx_isk bits are 0.
- ctrl priority:
  - BC0 = 8'h3C (K28.1).
  - Overflow = 8'hDC (K28.6).
  - Idle = 8'hBC (K28.5).
- Overflow coinciding with BC0 sets overflow_pending. The following frame then uses 8'hDC, and the pending flag clears on that frame.
- word_cnt counts 0..FRAME_WORDS-1.
  - bx_strobe forces a latch of the inputs and sets word_cnt=0 on the next cycle.
  - Without a strobe, word_cnt free-runs and wraps. The wrap also latches the inputs, so frames keep flowing.
- Strobe misalignment: a strobe arriving while word_cnt != FRAME_WORDS-1 increments sync_err_cnt, which saturates at 8'hFF. The strobe on the first cycle after reset is exempt.
- bx_cnt counts 0..BC0_PERIOD-1 and increments on every frame latch. A frame is BC0 when bx_cnt==0.
- ttc_resync sets bx_cnt to 0 at the next frame latch, so that latch is BC0. If resync and a latch coincide, the coinciding latch is the BC0.
- Test pattern: payload = the zero-extended 24-bit frame counter replicated across the payload width, truncated. The counter increments per frame and wraps at 2^24. ctrl rules are unchanged.
- inj_err: the first tx_data word output after the pulse has bit 8 inverted on lane 0 only. Further pulses before that word is sent are merged into one error.

## Timing
- Latency: inputs are sampled on the latch cycle (bx_strobe high, or wrap). Word 0 appears on tx_data one cycle later; words 1..FRAME_WORDS-1 follow on consecutive cycles.
- All outputs are registered.
- Reset values:
  - tx_data: each lane = 16'h00BC.
  - tx_isk: lane pattern 2'b01.
  - frame_start = 0, bc0_out = 0, sync_err_cnt = 0.
  - Internal state: word_cnt = FRAME_WORDS-1, bx_cnt = 0, overflow_pending = 0, inj pending = 0.
- While reset is high, the idle comma is sent every cycle. The first latch after release is a BC0 frame.
- Reset asserted mid-frame aborts the frame on the next cycle; no partial words are sent after reset.

## Structure
- Package gem_trigger_pkg holds:
  - K-character constants K28_1, K28_5, K28_6.
  - The frame-layout width functions.
- One sub-module, trigger_link_serializer: instantiated per lane. It latches a frame, muxes words by word_cnt and applies inj_err.
- Shared control logic stays in the top: word_cnt, bx_cnt, ctrl selection, sync_err_cnt.
- Target size is 200–300 lines.

## Test plan
- Default parameters, strobe every 4 cycles, cluster0=14'h1ABC:
  - lane 0 word 0 = {payload[7:0], 8'h3C} with isk=01 on the first frame.
  - 8'hBC on subsequent frames.
  - Lanes 0 and 2 identical.
- 3564 frames: bc0_out is high exactly once per 3564 frames. ttc_resync mid-orbit makes the next frame BC0.
- overflow=1 on a BC0 frame: that frame's ctrl = 8'h3C, the next frame's ctrl = 8'hDC, the frame after that 8'hBC.
- Strobe at word_cnt=1: sync_err_cnt becomes 1 and the frame restarts. 300 misaligned strobes hold the count at 8'hFF.
- ena_test_pat=1: the payload's low 24 bits increment by 1 per frame and wrap from 24'hFFFFFF to 0.
- inj_err pulse: exactly one word on lane 0 differs from expected, at bit 8. Reset asserted at word 2: the next cycle outputs 16'h00BC with isk=01.
